// File: rtl/move_scheduler.sv
// Move scheduler: coalesces rotate/left/right/down requests and issues one at a time
// to its executor, with down-first priority, round-robin among user moves and a busy timeout.
module move_scheduler #(
  parameter int timeout_p = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] cmd_v_i,
  input  logic       gravity_tick_i,
  input  logic       pause_i,
  output logic [3:0] exec_v_o,
  input  logic [3:0] exec_done_i,
  input  logic [3:0] exec_set_v_i,
  output logic       set_v_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int tw = $clog2(timeout_p + 1);

  typedef enum logic [1:0] {eIDLE, eIssue, eBusy} state_e;

  state_e        state;
  logic [3:0]    pending;
  logic [1:0]    rr_ptr;
  logic [1:0]    grant_q;
  logic [tw-1:0] timer;

  logic [3:0] set_bits;
  logic [3:0] clr_bits;
  logic       granted_done;
  logic       timer_hit;
  logic       finish;
  logic [1:0] sel;
  logic       found;
  logic [2:0] idx;

  assign set_bits     = {gravity_tick_i, cmd_v_i};
  assign granted_done = (state == eBusy) && exec_done_i[grant_q];
  assign timer_hit    = (state == eBusy) && (timer == tw'(timeout_p - 1)) && !granted_done;
  assign finish       = granted_done || timer_hit;
  assign clr_bits     = finish ? (4'b0001 << grant_q) : 4'b0000;

  // Down wins outright; otherwise scan user moves starting at rr_ptr, wrapping mod 3.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sel   = 2'd3;
    found = 1'b0;
    idx   = '0;
    if (!pending[3]) begin
      for (int i = 0; i < 3; i++) begin
        idx = {1'b0, rr_ptr} + 3'(i);
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (!found && pending[idx[1:0]]) begin
          sel   = idx[1:0];
          found = 1'b1;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= eIDLE;
      pending <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
      timer   <= '0;
    end else begin
      // A new request overrides a same-cycle clear so it is never lost.
      pending <= (pending & ~clr_bits) | set_bits;
      case (state)
        eIDLE: begin
          if ((|pending) && !pause_i) begin
            grant_q <= sel;
            if (sel != 2'd3) rr_ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            state <= eIssue;
          end
        end
        eIssue: begin
          timer <= '0;
          state <= eBusy;
        end
        eBusy: begin
          timer <= timer + tw'(1);
          if (finish) state <= eIDLE;
        end
        default: state <= eIDLE;
      endcase
    end
  end

  // Outputs decode registered state; reset forces them low in the cycle it is seen.
  assign busy_o    = !reset_i && (state != eIDLE);
  assign exec_v_o  = (!reset_i && (state == eIssue)) ? (4'b0001 << grant_q) : 4'b0000;
  assign set_v_o   = busy_o && exec_set_v_i[grant_q];
  assign grant_o   = reset_i ? 2'd0 : grant_q;
  assign done_o    = !reset_i && granted_done;
  assign timeout_o = !reset_i && timer_hit;

endmodule
